nios2_debug_cmd_dispatch: RTL and testbench

NIOS2_DEBUG_CMD_DISPATCH -- requirements
Module: nios2_debug_cmd_dispatch

---
 rtl/nios2_debug_cmd_dispatch.sv | 207 ++++++++++++++++++++
 tb/tb_nios2_debug_cmd_dispatch.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_debug_cmd_dispatch.sv
// ---------------------------------------------------------------------------
// nios2_debug_cmd_dispatch
//
// Buffers debug commands captured on update-DR strobes and hands them, one at
// a time, to the CPU debug logic. Each command is {instruction code, data
// word}. The instruction code selects one of NUM_CH channels. A bit of the
// data word chooses between a take_action and a take_no_action strobe. The
// dispatcher then waits for that channel's acknowledge before it issues the
// next command.
//
// Optional feature: define DEBUG_CMD_TIMEOUT_EN to bound the acknowledge wait
// to TIMEOUT cycles. On expiry the dispatcher sets timeout_err and moves on.
// Without the macro the wait is unbounded and timeout_err is tied to 0.
//
// Ports:
//   clk            in   sole clock, rising edge
//   reset_n        in   synchronous active-low reset
//   udr_pulse      in   single-cycle update-DR strobe (clk domain)
//   ir_in          in   [IR_W]    instruction code qualifying udr_pulse
//   sr_in          in   [DR_W]    shifted data word qualifying udr_pulse
//   cmd_ack        in   [NUM_CH]  per-channel completion acknowledge
//   clr_status     in   clears the sticky error flags
//   jdo            out  [DR_W]    data word of the command being dispatched
//   take_action    out  [NUM_CH]  one-hot single-cycle action strobe
//   take_no_action out  [NUM_CH]  one-hot single-cycle no-action strobe
//   busy           out  FSM not idle or buffer not empty
//   level          out  [log2(DEPTH)+1] buffer occupancy
//   overflow       out  sticky: a command was dropped
//   timeout_err    out  sticky: an acknowledge wait expired
// ---------------------------------------------------------------------------
module nios2_debug_cmd_dispatch #(
    parameter int IR_W    = 2,
    parameter int DR_W    = 38,
    parameter int DEPTH   = 4,
    parameter int ACT_BIT = 35,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     udr_pulse,
    input  logic [IR_W-1:0]          ir_in,
    input  logic [DR_W-1:0]          sr_in,
    input  logic [(2**IR_W)-1:0]     cmd_ack,
    input  logic                     clr_status,
    output logic [DR_W-1:0]          jdo,
    output logic [(2**IR_W)-1:0]     take_action,
    output logic [(2**IR_W)-1:0]     take_no_action,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     timeout_err
);

    localparam int NUM_CH = 2**IR_W;
    localparam int AW     = $clog2(DEPTH);
    localparam int EW     = IR_W + DR_W;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [EW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [EW-1:0]     head;
    logic [IR_W-1:0]   ch;
    logic [NUM_CH-1:0] ch_onehot;

    logic              pop;
    logic              push;
    logic              full;
    logic              drop;
    logic              ack_hit;
    logic              timeout_hit;
    logic [NUM_CH-1:0] act_nxt;
    logic [NUM_CH-1:0] noact_nxt;

    // A full buffer still accepts a push when the same cycle frees a slot.
    assign full      = (count == (AW+1)'(DEPTH));
    assign push      = udr_pulse && (!full || pop);
    assign drop      = udr_pulse && full && !pop;
    assign head      = mem[rd_ptr];
    assign ch_onehot = NUM_CH'(1) << ch;
    assign ack_hit   = cmd_ack[ch];

    assign level     = count;
    assign busy      = (state != IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Strobes are computed here and registered below, so
    // they appear for the single cycle after the ISSUE edge.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        act_nxt   = '0;
        noact_nxt = '0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (jdo[ACT_BIT]) begin
                    act_nxt = ch_onehot;
                end else begin
                    noact_nxt = ch_onehot;
                end
                state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ack_hit || timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Storage array carries no reset. Stale entries are unreachable once
    // the pointers and the count are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {ir_in, sr_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            jdo            <= '0;
            ch             <= '0;
            take_action    <= '0;
            take_no_action <= '0;
            overflow       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                jdo    <= head[DR_W-1:0];
                ch     <= head[EW-1:DR_W];
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
            take_action    <= act_nxt;
            take_no_action <= noact_nxt;
            // A new drop wins over a simultaneous clear.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_status) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef DEBUG_CMD_TIMEOUT_EN
    logic [15:0] wait_cnt;

    // wait_cnt holds the number of WAIT_ACK cycles already spent. The
    // TIMEOUT-th unacknowledged cycle ends the wait.
    assign timeout_hit = (state == WAIT_ACK) && !ack_hit &&
                         (wait_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT_ACK) begin
                wait_cnt <= wait_cnt + 16'(1);
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end else if (clr_status) begin
                timeout_err <= 1'b0;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_nios2_debug_cmd_dispatch.sv
// ---------------------------------------------------------------------------
// tb_nios2_debug_cmd_dispatch
//
// Self-checking bench for nios2_debug_cmd_dispatch. A reference model treats
// the command buffer as a bounded queue and the dispatcher as a single
// in-flight slot. When the model hands a command to the dispatcher, it pushes
// the expected strobe into a scoreboard. A monitor on the falling edge pops
// the scoreboard when a strobe is due or seen, and compares all outputs.
// Define DEBUG_CMD_TIMEOUT_EN for both DUT and bench to exercise timeouts.
// ---------------------------------------------------------------------------
module tb_nios2_debug_cmd_dispatch;

    localparam int IR_W    = 2;
    localparam int DR_W    = 38;
    localparam int DEPTH   = 4;
    localparam int ACT_BIT = 35;
    localparam int TMO     = 8;
    localparam int NUM_CH  = 2**IR_W;

    logic                   clk;
    logic                   reset_n;
    logic                   udr_pulse;
    logic [IR_W-1:0]        ir_in;
    logic [DR_W-1:0]        sr_in;
    logic [NUM_CH-1:0]      cmd_ack;
    logic                   clr_status;
    logic [DR_W-1:0]        jdo;
    logic [NUM_CH-1:0]      take_action;
    logic [NUM_CH-1:0]      take_no_action;
    logic                   busy;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow;
    logic                   timeout_err;

    nios2_debug_cmd_dispatch #(
        .IR_W    (IR_W),
        .DR_W    (DR_W),
        .DEPTH   (DEPTH),
        .ACT_BIT (ACT_BIT),
        .TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .udr_pulse      (udr_pulse),
        .ir_in          (ir_in),
        .sr_in          (sr_in),
        .cmd_ack        (cmd_ack),
        .clr_status     (clr_status),
        .jdo            (jdo),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .busy           (busy),
        .level          (level),
        .overflow       (overflow),
        .timeout_err    (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [IR_W-1:0] ch;
        logic [DR_W-1:0] data;
    } cmd_t;

    typedef struct {
        logic [IR_W-1:0] ch;
        logic            act;
        logic [DR_W-1:0] data;
        int              due;
    } exp_t;

    typedef enum int { M_READY, M_STROBE, M_AWAIT } mphase_t;

    cmd_t            m_buf[$];
    exp_t            sb[$];
    mphase_t         m_phase = M_READY;
    cmd_t            m_cur;
    logic [DR_W-1:0] m_jdo = '0;
    logic            m_ovf = 1'b0;
    logic            m_tmo = 1'b0;
    int              m_wait = 0;
    int              cyc = 0;
    bit              mon_en = 1'b0;
    int              n_vec = 0;
    int              n_err = 0;

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic udr, input logic [IR_W-1:0] ir,
                                 input logic [DR_W-1:0] sr,
                                 input logic [NUM_CH-1:0] ack,
                                 input logic clr, input logic rst_n);
        @(negedge clk);
        udr_pulse  = udr;
        ir_in      = ir;
        sr_in      = sr;
        cmd_ack    = ack;
        clr_status = clr;
        reset_n    = rst_n;
    endtask

    task automatic idleCycles(input int n, input logic [NUM_CH-1:0] ack);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, '0, '0, ack, 1'b0, 1'b1);
        end
    endtask

    // Reference model. Each edge first lets the dispatcher take the head, so
    // a push into a full queue succeeds when a slot is freed the same edge.
    always @(posedge clk) begin
        cmd_t c;
        bit   dropped;
        bit   expired;
        cyc++;
        dropped = 1'b0;
        expired = 1'b0;
        if (!reset_n) begin
            m_buf.delete();
            sb.delete();
            m_phase = M_READY;
            m_jdo   = '0;
            m_ovf   = 1'b0;
            m_tmo   = 1'b0;
            m_wait  = 0;
        end else begin
            case (m_phase)
                M_READY: begin
                    if (m_buf.size() > 0) begin
                        m_cur = m_buf.pop_front();
                        m_jdo = m_cur.data;
                        sb.push_back('{ch: m_cur.ch, act: m_cur.data[ACT_BIT],
                                       data: m_cur.data, due: cyc + 1});
                        m_phase = M_STROBE;
                    end
                end
                M_STROBE: begin
                    m_phase = M_AWAIT;
                    m_wait  = 0;
                end
                default: begin
                    if (cmd_ack[m_cur.ch]) begin
                        m_phase = M_READY;
                    end
`ifdef DEBUG_CMD_TIMEOUT_EN
                    else begin
                        m_wait++;
                        if (m_wait == TMO) begin
                            expired = 1'b1;
                            m_phase = M_READY;
                        end
                    end
`endif
                end
            endcase
            if (udr_pulse) begin
                if (m_buf.size() < DEPTH) begin
                    c.ch   = ir_in;
                    c.data = sr_in;
                    m_buf.push_back(c);
                end else begin
                    dropped = 1'b1;
                end
            end
            if (dropped) m_ovf = 1'b1;
            else if (clr_status) m_ovf = 1'b0;
            if (expired) m_tmo = 1'b1;
            else if (clr_status) m_tmo = 1'b0;
        end
    end

    // Monitor: pops the scoreboard whenever a strobe is due or observed.
    always @(negedge clk) begin
        logic [NUM_CH-1:0] ea;
        logic [NUM_CH-1:0] en;
        exp_t              e;
        if (mon_en) begin
            ea = '0;
            en = '0;
            if (((take_action | take_no_action) != '0) ||
                (sb.size() > 0 && sb[0].due == cyc)) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checkOutput("strobe_cycle", 64'(cyc), 64'(e.due));
                    if (e.act) ea[e.ch] = 1'b1;
                    else en[e.ch] = 1'b1;
                    checkOutput("strobe_jdo", 64'(jdo), 64'(e.data));
                end
            end
            checkOutput("take_action", 64'(take_action), 64'(ea));
            checkOutput("take_no_action", 64'(take_no_action), 64'(en));
            checkOutput("jdo", 64'(jdo), 64'(m_jdo));
            checkOutput("level", 64'(level), 64'(m_buf.size()));
            checkOutput("busy", 64'(busy),
                        64'((m_phase != M_READY) || (m_buf.size() > 0)));
            checkOutput("overflow", 64'(overflow), 64'(m_ovf));
            checkOutput("timeout_err", 64'(timeout_err), 64'(m_tmo));
        end
    end

    initial begin
        logic              u;
        logic [NUM_CH-1:0] a;
        logic              r;
        udr_pulse  = 1'b0;
        ir_in      = '0;
        sr_in      = '0;
        cmd_ack    = '0;
        clr_status = 1'b0;
        reset_n    = 1'b0;
        repeat (3) applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
        mon_en = 1'b1;
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
        idleCycles(2, '0);

        // Action command on channel 2, acked late, other channels ack first.
        applyStimulus(1'b1, 2'd2, 38'h8_0000_1234, '0, 1'b0, 1'b1);
        idleCycles(3, '0);
        idleCycles(1, 4'b1011);
        idleCycles(1, '0);
        idleCycles(1, 4'b0100);
        idleCycles(3, '0);

        // No-action command on channel 1.
        applyStimulus(1'b1, 2'd1, 38'h0_0000_00AB, '0, 1'b0, 1'b1);
        idleCycles(4, '0);
        idleCycles(1, 4'b0010);
        idleCycles(2, '0);

        // Acks during the idle and issue cycles must not retire the command.
        applyStimulus(1'b1, 2'd3, 38'h8_0000_0055, '1, 1'b0, 1'b1);
        idleCycles(2, '1);
        idleCycles(4, '0);
        idleCycles(2, 4'b1000);

        // Overflow: six back-to-back pushes with no ack.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, IR_W'(i), DR_W'(38'h8_0000_0100 + i), '0, 1'b0, 1'b1);
        end
        applyStimulus(1'b1, 2'd0, 38'h1, '0, 1'b1, 1'b1);
        idleCycles(2, '0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b1);
        idleCycles(30, '1);

        // Reset in the middle of a wait with two commands buffered.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, IR_W'(i + 1), DR_W'(38'h20 + i), '0, 1'b0, 1'b1);
        end
        idleCycles(2, '0);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
        idleCycles(12, '0);

        // Acknowledge never arrives: long wait (times out if enabled).
        applyStimulus(1'b1, 2'd0, 38'h8_0000_0777, '0, 1'b0, 1'b1);
        idleCycles(1000, '0);
        applyStimulus(1'b1, 2'd1, 38'h0_0000_0888, '0, 1'b0, 1'b1);
        idleCycles(20, '0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b1);
        idleCycles(30, '1);

        // Randomized traffic, acks, clears and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            u = ($urandom_range(0, 9) < 4);
            a = ($urandom_range(0, 9) < 3) ? NUM_CH'($urandom) : '0;
            r = ($urandom_range(0, 199) != 0);
            applyStimulus(u, IR_W'($urandom), DR_W'({$urandom, $urandom}), a,
                          ($urandom_range(0, 19) == 0), r);
        end
        idleCycles(40, '1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
